// File: rtl/antares_wb_stage.sv
// rtl/antares_wb_stage.sv - MEM/WB pipeline register and write-back data selection
module antares_wb_stage #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_gpr_wa,
  input  logic        mem_gpr_we,
  input  logic [31:0] mem_alu_result,
  input  logic        mem_mem_to_gpr,
  input  logic        mem_mem_byte,
  input  logic        mem_mem_halfword,
  input  logic        mem_mem_sign_ext,
  input  logic        mem_stall,
  input  logic        wb_stall,
  input  logic        wb_flush,
  input  logic [31:0] dmem_read_data,
  output logic [4:0]  gpr_wa,
  output logic [31:0] gpr_wd,
  output logic        gpr_we
);

  logic [4:0]  wa_q, wa_d;
  logic        we_q, we_d;
  logic [31:0] result_q, result_d;
  logic        mem_to_gpr_q, mem_to_gpr_d;
  logic        byte_q, byte_d;
  logic        half_q, half_d;
  logic        sign_ext_q, sign_ext_d;

  always_comb begin
    wa_d         = wa_q;
    we_d         = we_q;
    result_d     = result_q;
    mem_to_gpr_d = mem_to_gpr_q;
    byte_d       = byte_q;
    half_d       = half_q;
    sign_ext_d   = sign_ext_q;
    if (wb_stall) begin
      // hold everything; a concurrent flush is dropped and re-issued upstream
    end else if (wb_flush || mem_stall) begin
      wa_d         = 5'd0;
      we_d         = 1'b0;
      result_d     = 32'd0;
      mem_to_gpr_d = 1'b0;
      byte_d       = 1'b0;
      half_d       = 1'b0;
      sign_ext_d   = 1'b0;
    end else begin
      wa_d         = mem_gpr_wa;
      we_d         = mem_gpr_we;
      result_d     = mem_alu_result;
      mem_to_gpr_d = mem_mem_to_gpr;
      byte_d       = mem_mem_byte;
      half_d       = mem_mem_halfword;
      sign_ext_d   = mem_mem_sign_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wa_q         <= 5'd0;
      we_q         <= 1'b0;
      result_q     <= 32'd0;
      mem_to_gpr_q <= 1'b0;
      byte_q       <= 1'b0;
      half_q       <= 1'b0;
      sign_ext_q   <= 1'b0;
    end else begin
      wa_q         <= wa_d;
      we_q         <= we_d;
      result_q     <= result_d;
      mem_to_gpr_q <= mem_to_gpr_d;
      byte_q       <= byte_d;
      half_q       <= half_d;
      sign_ext_q   <= sign_ext_d;
    end
  end

  logic [1:0]  off;
  logic [1:0]  byte_idx;
  logic        half_upper;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val;

  assign off = result_q[1:0];
  // byte_idx counts lanes from bit 0 regardless of endianness
  assign byte_idx   = BIG_ENDIAN ? ~off : off;
  assign half_upper = BIG_ENDIAN ? ~off[1] : off[1];

  always_comb begin
    byte_lane = 8'd0;
    case (byte_idx)
      2'd0: byte_lane = dmem_read_data[7:0];
      2'd1: byte_lane = dmem_read_data[15:8];
      2'd2: byte_lane = dmem_read_data[23:16];
      2'd3: byte_lane = dmem_read_data[31:24];
      default: byte_lane = 8'd0;
    endcase
    half_lane = half_upper ? dmem_read_data[31:16] : dmem_read_data[15:0];
    load_val  = dmem_read_data;
    if (byte_q) begin
      load_val = {{24{sign_ext_q & byte_lane[7]}}, byte_lane};
    end else if (half_q) begin
      load_val = {{16{sign_ext_q & half_lane[15]}}, half_lane};
    end
  end

  assign gpr_wa = wa_q;
  assign gpr_wd = mem_to_gpr_q ? load_val : result_q;
  assign gpr_we = we_q & ~wb_stall & (wa_q != 5'd0);

endmodule

// File: tb/tb_antares_wb_stage.sv
// tb/tb_antares_wb_stage.sv - directed bench with write-back scoreboard for antares_wb_stage
module tb_antares_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  mem_gpr_wa;
  logic        mem_gpr_we;
  logic [31:0] mem_alu_result;
  logic        mem_mem_to_gpr;
  logic        mem_mem_byte;
  logic        mem_mem_halfword;
  logic        mem_mem_sign_ext;
  logic        mem_stall;
  logic        wb_stall;
  logic        wb_flush;
  logic [31:0] dmem_read_data;
  logic [4:0]  gpr_wa, le_wa;
  logic [31:0] gpr_wd, le_wd;
  logic        gpr_we, le_we;

  int checks = 0;
  int errors = 0;
  logic [36:0] sb_q[$];

  always #5 clk = ~clk;

  antares_wb_stage #(.BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .mem_gpr_wa(mem_gpr_wa), .mem_gpr_we(mem_gpr_we), .mem_alu_result(mem_alu_result),
    .mem_mem_to_gpr(mem_mem_to_gpr), .mem_mem_byte(mem_mem_byte),
    .mem_mem_halfword(mem_mem_halfword), .mem_mem_sign_ext(mem_mem_sign_ext),
    .mem_stall(mem_stall), .wb_stall(wb_stall), .wb_flush(wb_flush),
    .dmem_read_data(dmem_read_data),
    .gpr_wa(gpr_wa), .gpr_wd(gpr_wd), .gpr_we(gpr_we)
  );

  antares_wb_stage #(.BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst(rst),
    .mem_gpr_wa(mem_gpr_wa), .mem_gpr_we(mem_gpr_we), .mem_alu_result(mem_alu_result),
    .mem_mem_to_gpr(mem_mem_to_gpr), .mem_mem_byte(mem_mem_byte),
    .mem_mem_halfword(mem_mem_halfword), .mem_mem_sign_ext(mem_mem_sign_ext),
    .mem_stall(mem_stall), .wb_stall(wb_stall), .wb_flush(wb_flush),
    .dmem_read_data(dmem_read_data),
    .gpr_wa(le_wa), .gpr_wd(le_wd), .gpr_we(le_we)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_mem(input logic [4:0] wa, input logic we, input logic [31:0] res,
                         input logic m2g, input logic byt, input logic half, input logic sx);
    mem_gpr_wa       = wa;
    mem_gpr_we       = we;
    mem_alu_result   = res;
    mem_mem_to_gpr   = m2g;
    mem_mem_byte     = byt;
    mem_mem_halfword = half;
    mem_mem_sign_ext = sx;
  endtask

  task automatic idle();
    set_mem(5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every observed write must match the oldest expected write, in order
  always @(negedge clk) begin
    if (!rst && gpr_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_write_wa", {27'd0, gpr_wa}, 32'hFFFF_FFFF);
      end else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        chk("sb_wa", {27'd0, gpr_wa}, {27'd0, e[36:32]});
        chk("sb_wd", gpr_wd, e[31:0]);
      end
    end
  end

  logic [1:0]  ld_off  [9] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0, 2'd3, 2'd3, 2'd3, 2'd0};
  logic        ld_byte [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        ld_half [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        ld_sx   [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] ld_be   [9] = '{32'hFFFFFF80, 32'h000000FF, 32'h0000007F, 32'h00007F01,
                               32'hFFFF80FF, 32'h80FF7F01, 32'h00000001, 32'h00007F01,
                               32'h00000080};
  logic [31:0] ld_le   [9] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFF80FF,
                               32'h00007F01, 32'h80FF7F01, 32'hFFFFFF80, 32'h000080FF,
                               32'h00000001};
  logic [4:0]  st_wa   [4] = '{5'd1, 5'd2, 5'd3, 5'd1};

  initial begin
    idle();
    mem_stall      = 1'b0;
    wb_stall       = 1'b0;
    wb_flush       = 1'b0;
    dmem_read_data = 32'h80FF7F01;

    #2;
    chk("reset_we", {31'd0, gpr_we}, 32'd0);
    chk("reset_wa", {27'd0, gpr_wa}, 32'd0);
    chk("reset_wd", gpr_wd, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ALU write-back, exactly one pulse
    set_mem(5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    sb_q.push_back({5'd5, 32'hDEADBEEF});
    tick();
    chk("alu_we", {31'd0, gpr_we}, 32'd1);
    chk("alu_wa", {27'd0, gpr_wa}, 32'd5);
    chk("alu_wd", gpr_wd, 32'hDEADBEEF);
    idle();
    tick();
    chk("alu_we_once", {31'd0, gpr_we}, 32'd0);

    // Asynchronous reset mid-cycle discards a captured write
    set_mem(5'd7, 1'b1, 32'h0000_0055, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_we", {31'd0, gpr_we}, 32'd0);
    chk("async_rst_wa", {27'd0, gpr_wa}, 32'd0);
    chk("async_rst_wd", gpr_wd, 32'd0);
    tick();
    chk("in_rst_we", {31'd0, gpr_we}, 32'd0);
    chk("in_rst_wd", gpr_wd, 32'd0);
    idle();
    @(negedge clk);
    rst = 1'b0;

    // Sub-word loads, both byte orders
    for (int i = 0; i < 9; i++) begin
      set_mem(5'(8 + i), 1'b1, 32'h1000_0000 | {30'd0, ld_off[i]}, 1'b1,
              ld_byte[i], ld_half[i], ld_sx[i]);
      sb_q.push_back({5'(8 + i), ld_be[i]});
      tick();
      chk($sformatf("load_be_%0d", i), gpr_wd, ld_be[i]);
      chk($sformatf("load_le_%0d", i), le_wd, ld_le[i]);
    end

    // Register 0 is never written, data still driven
    set_mem(5'd0, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("r0_we", {31'd0, gpr_we}, 32'd0);
    chk("r0_wd", gpr_wd, 32'h0000_1234);

    // Three-cycle hold, with flush and new MEM data during the hold
    set_mem(5'd20, 1'b1, 32'hA5A5_0014, 1'b0, 1'b0, 1'b0, 1'b0);
    sb_q.push_back({5'd20, 32'hA5A5_0014});
    @(posedge clk);
    #1;
    wb_stall = 1'b1;
    set_mem(5'd21, 1'b1, 32'h0BAD_0015, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wb_flush = (i == 1);
      tick();
      chk($sformatf("hold_we_%0d", i), {31'd0, gpr_we}, 32'd0);
      chk($sformatf("hold_wa_%0d", i), {27'd0, gpr_wa}, 32'd20);
      chk($sformatf("hold_wd_%0d", i), gpr_wd, 32'hA5A5_0014);
    end
    wb_stall = 1'b0;
    wb_flush = 1'b0;
    idle();
    #1;
    chk("release_we", {31'd0, gpr_we}, 32'd1);
    tick();
    chk("release_once", {31'd0, gpr_we}, 32'd0);

    // Flush kills the entering instruction
    set_mem(5'd12, 1'b1, 32'h0000_00C0, 1'b0, 1'b0, 1'b0, 1'b0);
    wb_flush = 1'b1;
    tick();
    wb_flush = 1'b0;
    chk("flush_we", {31'd0, gpr_we}, 32'd0);
    chk("flush_wa", {27'd0, gpr_wa}, 32'd0);

    // MEM stall inserts a bubble
    set_mem(5'd13, 1'b1, 32'h0000_00D0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_stall = 1'b1;
    tick();
    mem_stall = 1'b0;
    chk("bubble_we", {31'd0, gpr_we}, 32'd0);
    chk("bubble_wd", gpr_wd, 32'd0);

    // Back-to-back stream, including a repeated destination
    for (int i = 0; i < 4; i++) begin
      set_mem(st_wa[i], 1'b1, 32'h5000_0000 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      sb_q.push_back({st_wa[i], 32'h5000_0000 + 32'(i)});
      tick();
      chk($sformatf("stream_we_%0d", i), {31'd0, gpr_we}, 32'd1);
    end
    idle();
    tick();
    chk("stream_end_we", {31'd0, gpr_we}, 32'd0);
    tick();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
